// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - control strobe bundle between sequencer and datapath
interface control_sequencer_if;
    logic [31:0] IR;
    logic        Branch;
    logic        stop;
    logic        PCout, PCin, IncPc;
    logic        MARin;
    logic        MDRin, MDRout;
    logic [1:0]  mdr_read;
    logic        read, write;
    logic        IRin;
    logic        Yin;
    logic        Zlowin, Zlowout;
    logic [3:0]  control;
    logic        Rin, Rout, BAout;
    logic        GRA, GRB, GRC;
    logic        Cout;
    logic        CONin;
    logic        InPortout, OutPortin;
    logic        run;
    logic        done;

    modport master (
        input  IR, Branch, stop,
        output PCout, PCin, IncPc, MARin, MDRin, MDRout, mdr_read, read, write,
               IRin, Yin, Zlowin, Zlowout, control, Rin, Rout, BAout,
               GRA, GRB, GRC, Cout, CONin, InPortout, OutPortin, run, done
    );

    modport slave (
        output IR, Branch, stop,
        input  PCout, PCin, IncPc, MARin, MDRin, MDRout, mdr_read, read, write,
               IRin, Yin, Zlowin, Zlowout, control, Rin, Rout, BAout,
               GRA, GRB, GRC, Cout, CONin, InPortout, OutPortin, run, done
    );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute step sequencer
module control_sequencer #(
    parameter logic [3:0] ALU_ADD = 4'd2,
    parameter logic [3:0] ALU_SUB = 4'd3,
    parameter logic [3:0] ALU_AND = 4'd4,
    parameter logic [3:0] ALU_OR  = 4'd5
) (
    input  logic                clk,
    input  logic                reset,
    control_sequencer_if.master bus
);
    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110, OP_BR   = 5'b10010, OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110, OP_OUT  = 5'b10111, OP_HALT = 5'b11001;

    typedef enum logic [3:0] {
        S_RST = 4'd0, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t      state, state_next;
    logic [4:0]  opcode;
    logic [3:0]  alu_op;
    logic        done_s;
    logic        unused_ir;

    assign opcode    = bus.IR[31:27];
    assign unused_ir = ^bus.IR[26:0];

    always_ff @(posedge clk) begin
        if (reset) state <= S_RST;
        else       state <= state_next;
    end

    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_SUB:          alu_op = ALU_SUB;
            OP_AND, OP_ANDI: alu_op = ALU_AND;
            OP_OR,  OP_ORI:  alu_op = ALU_OR;
            default:         alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        bus.PCout = 1'b0; bus.PCin = 1'b0; bus.IncPc = 1'b0; bus.MARin = 1'b0;
        bus.MDRin = 1'b0; bus.MDRout = 1'b0; bus.mdr_read = 2'b00;
        bus.read = 1'b0; bus.write = 1'b0; bus.IRin = 1'b0; bus.Yin = 1'b0;
        bus.Zlowin = 1'b0; bus.Zlowout = 1'b0; bus.control = 4'd0;
        bus.Rin = 1'b0; bus.Rout = 1'b0; bus.BAout = 1'b0;
        bus.GRA = 1'b0; bus.GRB = 1'b0; bus.GRC = 1'b0; bus.Cout = 1'b0;
        bus.CONin = 1'b0; bus.InPortout = 1'b0; bus.OutPortin = 1'b0;
        bus.run = (state != S_RST) && (state != S_HALT);
        done_s = 1'b0;
        state_next = state;

        case (state)
            S_RST:  state_next = S_T0;
            S_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPc = 1'b1; bus.Zlowin = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.read = 1'b1;
                bus.MDRin = 1'b1; bus.mdr_read = 2'b01;
                state_next = S_T2;
            end
            S_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin bus.GRB = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                        bus.GRB = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                    end
                    OP_BR:  begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
                    OP_JR:  begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; done_s = 1'b1; end
                    OP_IN:  begin bus.InPortout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; done_s = 1'b1; end
                    OP_OUT: begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.OutPortin = 1'b1; done_s = 1'b1; end
                    default: done_s = 1'b1;
                endcase
                state_next = S_T4;
            end
            // Unreachable (step, opcode) pairs finish the instruction so the FSM can never run past T7.
            S_T4: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin bus.Cout = 1'b1; bus.Zlowin = 1'b1; bus.control = ALU_ADD; end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        bus.GRC = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1; bus.control = alu_op;
                    end
                    OP_ADDI, OP_ANDI, OP_ORI: begin bus.Cout = 1'b1; bus.Zlowin = 1'b1; bus.control = alu_op; end
                    OP_BR:   begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
                    default: done_s = 1'b1;
                endcase
                state_next = S_T5;
            end
            S_T5: begin
                case (opcode)
                    OP_LD, OP_ST: begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
                    OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                        bus.Zlowout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; done_s = 1'b1;
                    end
                    OP_BR:   begin bus.Cout = 1'b1; bus.Zlowin = 1'b1; bus.control = ALU_ADD; end
                    default: done_s = 1'b1;
                endcase
                state_next = S_T6;
            end
            S_T6: begin
                case (opcode)
                    OP_LD:   begin bus.read = 1'b1; bus.MDRin = 1'b1; bus.mdr_read = 2'b01; end
                    OP_ST:   begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
                    OP_BR:   begin bus.Zlowout = 1'b1; bus.PCin = bus.Branch; done_s = 1'b1; end
                    default: done_s = 1'b1;
                endcase
                state_next = S_T7;
            end
            S_T7: begin
                case (opcode)
                    OP_LD:   begin bus.MDRout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; done_s = 1'b1; end
                    OP_ST:   begin bus.write = 1'b1; done_s = 1'b1; end
                    default: done_s = 1'b1;
                endcase
            end
            default: state_next = S_HALT;
        endcase

        if (done_s)
            state_next = (bus.stop || (opcode == OP_HALT)) ? S_HALT : S_T0;
        bus.done = done_s;
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    control_sequencer_if sif();
    control_sequencer dut (.clk(clk), .reset(reset), .bus(sif));

    localparam logic [29:0] M_PCOUT  = 30'd1 << 29, M_PCIN   = 30'd1 << 28, M_INCPC  = 30'd1 << 27;
    localparam logic [29:0] M_MARIN  = 30'd1 << 26, M_MDRIN  = 30'd1 << 25, M_MDROUT = 30'd1 << 24;
    localparam logic [29:0] M_MR01   = 30'd1 << 22, M_READ   = 30'd1 << 21, M_WRITE  = 30'd1 << 20;
    localparam logic [29:0] M_IRIN   = 30'd1 << 19, M_YIN    = 30'd1 << 18, M_ZLIN   = 30'd1 << 17;
    localparam logic [29:0] M_ZLOUT  = 30'd1 << 16, M_RIN    = 30'd1 << 11, M_ROUT   = 30'd1 << 10;
    localparam logic [29:0] M_BAOUT  = 30'd1 << 9,  M_GRA    = 30'd1 << 8,  M_GRB    = 30'd1 << 7;
    localparam logic [29:0] M_GRC    = 30'd1 << 6,  M_COUT   = 30'd1 << 5,  M_CONIN  = 30'd1 << 4;
    localparam logic [29:0] M_INPO   = 30'd1 << 3,  M_OUTPI  = 30'd1 << 2,  M_RUN    = 30'd1 << 1;
    localparam logic [29:0] M_DONE   = 30'd1;
    localparam logic [29:0] C2 = 30'd2 << 12, C3 = 30'd3 << 12, C4 = 30'd4 << 12, C5 = 30'd5 << 12;

    localparam logic [29:0] E_T0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLIN;
    localparam logic [29:0] E_T1 = M_RUN | M_ZLOUT | M_PCIN | M_READ | M_MDRIN | M_MR01;
    localparam logic [29:0] E_T2 = M_RUN | M_MDROUT | M_IRIN;
    localparam logic [29:0] E_MEM_T3 = M_RUN | M_GRB | M_BAOUT | M_YIN;
    localparam logic [29:0] E_MEM_T4 = M_RUN | M_COUT | M_ZLIN | C2;
    localparam logic [29:0] E_WB_T5  = M_RUN | M_ZLOUT | M_GRA | M_RIN | M_DONE;
    localparam logic [29:0] E_ALU_T3 = M_RUN | M_GRB | M_ROUT | M_YIN;

    logic [29:0] got;
    assign got = {sif.PCout, sif.PCin, sif.IncPc, sif.MARin, sif.MDRin, sif.MDRout, sif.mdr_read,
                  sif.read, sif.write, sif.IRin, sif.Yin, sif.Zlowin, sif.Zlowout, sif.control,
                  sif.Rin, sif.Rout, sif.BAout, sif.GRA, sif.GRB, sif.GRC, sif.Cout, sif.CONin,
                  sif.InPortout, sif.OutPortin, sif.run, sif.done};

    logic [29:0] exp_q[$];
    string       nm_q[$];
    int          compared = 0;
    int          mismatched = 0;

    always @(negedge clk) begin : monitor
        logic [29:0] e;
        string       n;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL %s: got %h expected %h", n, got, e);
            end
        end
    end

    task automatic step(input logic [29:0] e, input string nm);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [4:0] op);
        sif.IR = {op, 27'h2A5A5A5};
        step(E_T0, "fetch_t0");
        step(E_T1, "fetch_t1");
        step(E_T2, "fetch_t2");
    endtask

    task automatic do_reset(input logic [29:0] cur, input string nm);
        reset = 1'b1;
        step(cur, nm);
        step(30'd0, "rst_hold1");
        reset = 1'b0;
        step(30'd0, "rst_hold2");
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset = 1'b1;
        sif.IR = 32'd0; sif.Branch = 1'b0; sif.stop = 1'b0;
        @(posedge clk); #1;
        step(30'd0, "rst_a");
        reset = 1'b0;
        step(30'd0, "rst_b");

        fetch(5'b00001);
        step(E_MEM_T3, "ldi_t3"); step(E_MEM_T4, "ldi_t4"); step(E_WB_T5, "ldi_t5");

        fetch(5'b00100);
        step(E_ALU_T3, "sub_t3");
        step(M_RUN | M_GRC | M_ROUT | M_ZLIN | C3, "sub_t4");
        step(E_WB_T5, "sub_t5");

        fetch(5'b00101);
        step(E_ALU_T3, "and_t3");
        step(M_RUN | M_GRC | M_ROUT | M_ZLIN | C4, "and_t4");
        step(E_WB_T5, "and_t5");

        fetch(5'b01110);
        step(E_ALU_T3, "ori_t3");
        step(M_RUN | M_COUT | M_ZLIN | C5, "ori_t4");
        step(E_WB_T5, "ori_t5");

        fetch(5'b10010);
        sif.Branch = 1'b1;
        step(M_RUN | M_GRA | M_ROUT | M_CONIN, "br1_t3");
        step(M_RUN | M_PCOUT | M_YIN, "br1_t4");
        step(M_RUN | M_COUT | M_ZLIN | C2, "br1_t5");
        step(M_RUN | M_ZLOUT | M_PCIN | M_DONE, "br1_t6");

        fetch(5'b10010);
        step(M_RUN | M_GRA | M_ROUT | M_CONIN, "br0_t3");
        step(M_RUN | M_PCOUT | M_YIN, "br0_t4");
        step(M_RUN | M_COUT | M_ZLIN | C2, "br0_t5");
        sif.Branch = 1'b0;
        step(M_RUN | M_ZLOUT | M_DONE, "br0_t6");

        fetch(5'b00010);
        step(E_MEM_T3, "st_t3"); step(E_MEM_T4, "st_t4");
        step(M_RUN | M_ZLOUT | M_MARIN, "st_t5");
        step(M_RUN | M_GRA | M_ROUT | M_MDRIN, "st_t6");
        step(M_RUN | M_WRITE | M_DONE, "st_t7");

        fetch(5'b00000);
        step(E_MEM_T3, "ld_t3"); step(E_MEM_T4, "ld_t4");
        step(M_RUN | M_ZLOUT | M_MARIN, "ld_t5");
        step(M_RUN | M_READ | M_MDRIN | M_MR01, "ld_t6");
        step(M_RUN | M_MDROUT | M_GRA | M_RIN | M_DONE, "ld_t7");

        fetch(5'b10100); step(M_RUN | M_GRA | M_ROUT | M_PCIN | M_DONE, "jr_t3");
        fetch(5'b10110); step(M_RUN | M_INPO | M_GRA | M_RIN | M_DONE, "in_t3");
        fetch(5'b10111); step(M_RUN | M_GRA | M_ROUT | M_OUTPI | M_DONE, "out_t3");
        fetch(5'b11000); step(M_RUN | M_DONE, "nop_t3");
        fetch(5'b11111); step(M_RUN | M_DONE, "undef_t3");

        fetch(5'b00001);
        sif.stop = 1'b1;
        step(E_MEM_T3, "ldi_stop_t3"); step(E_MEM_T4, "ldi_stop_t4");
        sif.stop = 1'b0;
        step(E_WB_T5, "ldi_stop_t5");

        fetch(5'b11000);
        sif.stop = 1'b1;
        step(M_RUN | M_DONE, "nop_stop_t3");
        for (int i = 0; i < 10; i++) begin
            sif.stop = i[0];
            step(30'd0, "stop_halt_hold");
        end
        sif.stop = 1'b0;
        do_reset(30'd0, "stop_halt_rst");

        fetch(5'b11001);
        step(M_RUN | M_DONE, "halt_t3");
        for (int i = 0; i < 10; i++) step(30'd0, "halt_hold");
        do_reset(30'd0, "halt_rst");

        fetch(5'b00000);
        step(E_MEM_T3, "ldab_t3"); step(E_MEM_T4, "ldab_t4");
        reset = 1'b1;
        step(M_RUN | M_ZLOUT | M_MARIN, "ldab_t5");
        reset = 1'b0;
        step(30'd0, "ldab_rst");
        fetch(5'b11000);
        step(M_RUN | M_DONE, "final_nop_t3");
        step(E_T0, "final_t0");

        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
